// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor.
//   MODE_TWOS / MODE_ONES : values of the mode input.
//   state_t               : controller state encoding (also seen on dbg_state).
package sub_pkg;

  localparam logic MODE_TWOS = 1'b0;
  localparam logic MODE_ONES = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_WRAP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sub_slice.sv
// STEP-bit combinational ripple adder shared by the subtract pass and the
// end-around-carry pass of serial_subtractor.
//   x, y : addends (STEP bits)
//   cin  : carry in
//   s    : sum (STEP bits)
//   cout : carry out of the top bit
module sub_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] x,
  input  logic [STEP-1:0] y,
  input  logic            cin,
  output logic [STEP-1:0] s,
  output logic            cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < STEP; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle A - B in two's- or one's-complement, STEP bits per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, mode  : request (sampled in IDLE only), 0 = two's, 1 = one's
//   a, b         : operands, latched when start is accepted
//   ready, busy  : ready = IDLE, busy = SUB/WRAP/DONE
//   done         : one-cycle pulse, diff and flags valid while high
//   diff         : result, held until the next accepted start
//   borrow       : inverted carry-out of the subtract pass
//   overflow     : signed overflow of the selected representation
//   neg_zero     : one's-complement result is all ones
//   dbg_state    : current controller state
//
// Handshake: a request is accepted on a rising edge where start = 1 and
// ready = 1; start while ready = 0 is dropped, never queued.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             neg_zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / STEP;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             borrow_q, borrow_d, overflow_q, overflow_d;
  logic             neg_zero_q, neg_zero_d, done_q, done_d;

  logic             last_chunk;
  logic [31:0]      sh;
  logic [WIDTH-1:0] x_full, x_sh, y_sh, s_ext, step_mask;
  logic [STEP-1:0]  slice_x, slice_y, slice_s;
  logic             slice_cout;

  assign last_chunk = (idx_q == IW'(N - 1));

  // Chunk select: shift the active operand down so chunk idx sits at bit 0.
  // The WRAP pass re-reads diff and adds zero plus the running carry.
  always_comb begin
    sh        = {{(32-IW){1'b0}}, idx_q} * STEP;
    x_full    = (state_q == ST_SUB) ? a_q : diff_q;
    x_sh      = x_full >> sh;
    y_sh      = (~b_q) >> sh;
    slice_x   = x_sh[STEP-1:0];
    slice_y   = (state_q == ST_SUB) ? y_sh[STEP-1:0] : '0;
    s_ext     = '0;
    s_ext[STEP-1:0] = slice_s;
    step_mask = '0;
    step_mask[STEP-1:0] = '1;
  end

  sub_slice #(.STEP(STEP)) u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SUB;
      ST_SUB:  if (last_chunk)
                 state_d = (mode_q == MODE_ONES && slice_cout) ? ST_WRAP : ST_DONE;
      ST_WRAP: if (last_chunk) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready     = (state_q == ST_IDLE);
    busy      = ~ready;
    dbg_state = state_q;
  end

  // Datapath next values
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    neg_zero_d = neg_zero_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        mode_d  = mode;
        idx_d   = '0;
        // Two's complement needs the +1 of ~b; one's complement adds it later
        // only if the end-around carry appears.
        carry_d = (mode == MODE_TWOS);
      end
      ST_SUB, ST_WRAP: begin
        diff_d  = (diff_q & ~(step_mask << sh)) | (s_ext << sh);
        carry_d = slice_cout;
        idx_d   = last_chunk ? '0 : idx_q + IW'(1);
        if (state_q == ST_SUB && last_chunk) borrow_d = ~slice_cout;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
        neg_zero_d = (mode_q == MODE_ONES) && (&diff_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      neg_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      neg_zero_q <= neg_zero_d;
      done_q     <= done_d;
    end
  end

  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign neg_zero = neg_zero_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // WIDTH=4 STEP=1 instance (N=4)
  logic       d4_start, d4_mode, d4_ready, d4_busy, d4_done, d4_borrow, d4_ovf, d4_nz;
  logic [3:0] d4_a, d4_b, d4_diff;
  logic [1:0] d4_st;
  // WIDTH=8 STEP=2 instance (N=4)
  logic       d8_start, d8_mode, d8_ready, d8_busy, d8_done, d8_borrow, d8_ovf, d8_nz;
  logic [7:0] d8_a, d8_b, d8_diff;
  logic [1:0] d8_st;

  serial_subtractor #(.WIDTH(4), .STEP(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(d4_start), .mode(d4_mode), .a(d4_a), .b(d4_b),
    .ready(d4_ready), .busy(d4_busy), .done(d4_done), .diff(d4_diff), .borrow(d4_borrow),
    .overflow(d4_ovf), .neg_zero(d4_nz), .dbg_state(d4_st)
  );

  serial_subtractor #(.WIDTH(8), .STEP(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(d8_start), .mode(d8_mode), .a(d8_a), .b(d8_b),
    .ready(d8_ready), .busy(d8_busy), .done(d8_done), .diff(d8_diff), .borrow(d8_borrow),
    .overflow(d8_ovf), .neg_zero(d8_nz), .dbg_state(d8_st)
  );

  // Selected-instance view
  int         sel;
  logic       c_ready, c_busy, c_done, c_borrow, c_ovf, c_nz;
  logic [7:0] c_diff;
  logic [1:0] c_st;
  always_comb begin
    if (sel == 1) begin
      c_ready = d8_ready; c_busy = d8_busy; c_done = d8_done; c_borrow = d8_borrow;
      c_ovf = d8_ovf; c_nz = d8_nz; c_diff = d8_diff; c_st = d8_st;
    end else begin
      c_ready = d4_ready; c_busy = d4_busy; c_done = d4_done; c_borrow = d4_borrow;
      c_ovf = d4_ovf; c_nz = d4_nz; c_diff = {4'b0, d4_diff}; c_st = d4_st;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {latency[7:0], neg_zero, overflow, borrow, diff[7:0]}
  logic [18:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: true signed values and range checks.
  function automatic logic [18:0] model(input int w, input int n, input bit m,
                                        input logic [7:0] a, input logic [7:0] b);
    int mask, half, ai, bi, raw, d, lat, sa, sb, tv, hi, lo;
    bit brw, ovf, nz;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ai = int'(a) & mask;
    bi = int'(b) & mask;
    if (!m) begin
      d   = (ai - bi) & mask;
      brw = (ai < bi);
      lat = n + 1;
      sa  = (ai >= half) ? ai - (1 << w) : ai;
      sb  = (bi >= half) ? bi - (1 << w) : bi;
      hi  = half - 1;
      lo  = -half;
    end else begin
      raw = ai + ((~bi) & mask);
      brw = ((raw >> w) == 0);
      d   = brw ? raw : ((raw + 1) & mask);
      lat = brw ? n + 1 : 2 * n + 1;
      sa  = (ai >= half) ? -((~ai) & mask) : ai;
      sb  = (bi >= half) ? -((~bi) & mask) : bi;
      hi  = half - 1;
      lo  = -(half - 1);
    end
    tv  = sa - sb;
    ovf = (tv > hi) || (tv < lo);
    nz  = m && (d == mask);
    return {8'(lat), nz, ovf, brw, 8'(d)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_in(input int s, input bit st, input bit m,
                          input logic [7:0] a, input logic [7:0] b);
    if (s == 1) begin
      d8_start = st; d8_mode = m; d8_a = a; d8_b = b;
    end else begin
      d4_start = st; d4_mode = m; d4_a = a[3:0]; d4_b = b[3:0];
    end
  endtask

  task automatic run_op(input int s, input bit m, input logic [7:0] a, input logic [7:0] b,
                        input bit poke, input string tag);
    logic [18:0] e;
    logic [7:0]  held;
    int lat;
    bit got;
    sel = s;
    @(negedge clk);
    drive_in(s, 1'b1, m, a, b);
    exp_q.push_back(model((s == 1) ? 8 : 4, 4, m, a, b));
    @(posedge clk); #1;
    // operands are free to change after acceptance
    drive_in(s, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)));
    check({tag, "_busy"}, c_busy, 1);
    got = 0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (poke && i == 2)
        drive_in(s, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
      else
        drive_in(s, 1'b0, m, a, b);
      @(posedge clk); #1;
      lat = i;
      if (c_done) got = 1;
      else check({tag, "_ready_low"}, c_ready, 0);
    end
    drive_in(s, 1'b0, m, a, b);
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, lat, e[18:11]);
    check({tag, "_diff"}, c_diff, e[7:0]);
    check({tag, "_borrow"}, c_borrow, e[8]);
    check({tag, "_overflow"}, c_ovf, e[9]);
    check({tag, "_neg_zero"}, c_nz, e[10]);
    check({tag, "_ready_at_done"}, c_ready, 1);
    held = c_diff;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, c_done, 0);
    check({tag, "_diff_held"}, c_diff, held);
    if (poke) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check({tag, "_no_extra_done"}, c_done, 0);
      end
    end
  endtask

  task automatic check_idle_reset(input int s, input string tag);
    sel = s;
    #0;
    check({tag, "_state"}, c_st, ST_IDLE);
    check({tag, "_ready"}, c_ready, 1);
    check({tag, "_busy"}, c_busy, 0);
    check({tag, "_done"}, c_done, 0);
    check({tag, "_diff"}, c_diff, 0);
    check({tag, "_borrow"}, c_borrow, 0);
    check({tag, "_overflow"}, c_ovf, 0);
    check({tag, "_neg_zero"}, c_nz, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel = 0;
    rst_n = 1'b0;
    drive_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset(0, "rst4");
    check_idle_reset(1, "rst8");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 1'b1, 8'h07, 8'h05, 1'b0, "t1_ones_wrap");
    run_op(0, 1'b1, 8'h0A, 8'h07, 1'b0, "t2_ones_wrap");
    run_op(0, 1'b1, 8'h05, 8'h05, 1'b0, "t2_neg_zero");
    run_op(1, 1'b0, 8'h00, 8'h57, 1'b0, "t3_twos_borrow");
    run_op(1, 1'b0, 8'h80, 8'h01, 1'b0, "t4_twos_ovf");
    run_op(1, 1'b0, 8'h01, 8'h01, 1'b0, "t4_twos_zero");
    run_op(1, 1'b0, 8'h35, 8'hC2, 1'b1, "t5_ignore8");
    run_op(0, 1'b1, 8'h0C, 8'h03, 1'b1, "t5_ignore4");

    // reset in the middle of the subtract pass (chunk 2 of 4)
    sel = 0;
    @(negedge clk);
    drive_in(0, 1'b1, 1'b0, 8'h0B, 8'h02);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(posedge clk); #2;
    check("t6_pre_state", c_st, ST_SUB);
    rst_n = 1'b0;
    #1;
    check_idle_reset(0, "t6_mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 8'h09, 8'h04, 1'b0, "t6_after");

    for (int i = 0; i < 24; i++)
      run_op(i % 2, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'b0, "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
